// File: rtl/reset_request_scheduler.sv
// Domain reset sequencer: ordered power-on release, then arbitrated soft-reset requests with 4-phase ack.
// Optional RESET_SCHED_RR_EN: round-robin grant in IDLE instead of fixed lowest-index priority.
module reset_request_scheduler #(
    parameter int NUM_REQ      = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int STEP_CYCLES  = 4,
    parameter int NO_INTERCNCT = 1,
    parameter int NO_PERIFERAL = 1,
    parameter int NO_PROCESSOR = 1,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    async_reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [2*NUM_REQ-1:0]    req_scope,
    output logic [NUM_REQ-1:0]      ack,
    output logic [NO_INTERCNCT-1:0] intercnct_reset,
    output logic [NO_PERIFERAL-1:0] periferal_reset,
    output logic [NO_PROCESSOR-1:0] processor_reset,
    output logic                    busy,
    output logic [GW-1:0]           grant_id
);

    localparam int MAXC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        POR_HOLD, IDLE, ASSERT_PROC, ASSERT_PERI, ASSERT_ICN,
        HOLD, REL_ICN, REL_PERI, REL_PROC, ACK
    } state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt;
    logic           por_q;
    logic [1:0]     scope_q;
    logic [GW-1:0]  gid_q;
    logic           step_done, hold_done;
    int             gnt_int;
    int             rr_start;

    assign step_done = (cnt == CW'(STEP_CYCLES - 1));
    assign hold_done = (cnt == CW'(HOLD_CYCLES - 1));
    assign grant_id  = gid_q;

`ifdef RESET_SCHED_RR_EN
    logic [GW-1:0] rr_ptr;

    assign rr_start = int'(rr_ptr);

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset)
            rr_ptr <= '0;
        else if (state == IDLE && |req)
            rr_ptr <= (gnt_int == NUM_REQ - 1) ? '0 : GW'(gnt_int + 1);
    end
`else
    assign rr_start = 0;
`endif

    // Reverse scan so the last hit is the first requester at or after rr_start.
    always_comb begin
        gnt_int = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(rr_start + i) % NUM_REQ])
                gnt_int = (rr_start + i) % NUM_REQ;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            POR_HOLD:    if (hold_done) state_d = REL_ICN;
            IDLE:        if (|req) state_d = ASSERT_PROC;
            ASSERT_PROC: if (step_done) state_d = (scope_q != 2'b00) ? ASSERT_PERI : HOLD;
            ASSERT_PERI: if (step_done) state_d = scope_q[1] ? ASSERT_ICN : HOLD;
            ASSERT_ICN:  if (step_done) state_d = HOLD;
            HOLD:        if (hold_done)
                             state_d = scope_q[1] ? REL_ICN : (scope_q[0] ? REL_PERI : REL_PROC);
            REL_ICN:     if (step_done) state_d = REL_PERI;
            REL_PERI:    if (step_done) state_d = REL_PROC;
            REL_PROC:    if (step_done) state_d = por_q ? IDLE : ACK;
            ACK:         if (!req[gid_q]) state_d = IDLE;
            default:     state_d = POR_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state           <= POR_HOLD;
            cnt             <= '0;
            por_q           <= 1'b1;
            scope_q         <= 2'b00;
            gid_q           <= '0;
            ack             <= '0;
            busy            <= 1'b1;
            intercnct_reset <= '1;
            periferal_reset <= '1;
            processor_reset <= '1;
        end else begin
            state <= state_d;
            cnt   <= (state_d != state) ? '0 : cnt + CW'(1);
            busy  <= (state_d != IDLE);
            if (state == IDLE && |req) begin
                gid_q   <= GW'(gnt_int);
                scope_q <= req_scope[2*gnt_int +: 2];
            end
            // Reset outputs only move on entry to their own step, so out-of-scope ones stay put.
            if (state_d != state) begin
                case (state_d)
                    ASSERT_PROC: processor_reset <= '1;
                    ASSERT_PERI: periferal_reset <= '1;
                    ASSERT_ICN:  intercnct_reset <= '1;
                    REL_ICN:     intercnct_reset <= '0;
                    REL_PERI:    periferal_reset <= '0;
                    REL_PROC:    processor_reset <= '0;
                    ACK: begin
                        for (int i = 0; i < NUM_REQ; i++)
                            ack[i] <= (gid_q == GW'(i));
                    end
                    IDLE: begin
                        ack   <= '0;
                        gid_q <= '0;
                        por_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/reset_request_scheduler.md
Name: reset_request_scheduler

Overview:
- Owns the domain reset outputs after power-on.
- Releases interconnect, peripheral and processor resets in order after async_reset, then serves soft-reset requests from NUM_REQ requesters (watchdog, debug, software register).
- Arbitrates the requesters, then runs an ordered assert, hold and release sequence over the requested scope, and acknowledges with a 4-phase handshake.
- Runs in the slowest synchronous clock domain, downstream of the reset synchronizer.

Parameters:
NUM_REQ, 3, number of requesters (1..8)
HOLD_CYCLES, 16, cycles all in-scope resets stay asserted before release begins (>=1)
STEP_CYCLES, 4, cycles spent in each assert/release step (>=1)
NO_INTERCNCT, 1, width of intercnct_reset
NO_PERIFERAL, 1, width of periferal_reset
NO_PROCESSOR, 1, width of processor_reset

Ports:
clk  input  1  slowest-sync-clock
async_reset  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester soft-reset request, level, held until ack
req_scope  input  2*NUM_REQ  scope per requester, bits [2i+1:2i]: 00 processor, 01 peripheral+processor, 1x full (adds interconnect)
ack  output  NUM_REQ  per-requester acknowledge
intercnct_reset  output  NO_INTERCNCT  interconnect reset, active-high
periferal_reset  output  NO_PERIFERAL  peripheral reset, active-high
processor_reset  output  NO_PROCESSOR  processor reset, active-high
busy  output  1  high whenever state != IDLE
grant_id  output  $clog2(NUM_REQ) (min 1)  index of the requester being served; 0 when idle

Behaviour:
- Clock and reset: one clock, clk. async_reset is asynchronous and active-high.
- Reset values while async_reset=1:
  - All reset outputs are all-ones.
  - ack=0, busy=1, grant_id=0.
  - State is POR_HOLD and the counter is 0.
- All outputs are registered. A reset output changes on the clk edge that enters the state named for it.
- States: POR_HOLD, IDLE, ASSERT_PROC, ASSERT_PERI, ASSERT_ICN, HOLD, REL_ICN, REL_PERI, REL_PROC, ACK.
- Counter:
  - Width is $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1).
  - Clears on every state change and increments otherwise.
  - A step state exits on the edge where count==STEP_CYCLES-1.
  - POR_HOLD and HOLD exit on the edge where count==HOLD_CYCLES-1.
- Power-on sequence: POR_HOLD -> REL_ICN -> REL_PERI -> REL_PROC -> IDLE. There is no ack.
- IDLE:
  - If any req bit is set, grant the lowest index: latch grant_id and its scope.
  - Enter ASSERT_PROC on the same edge; processor_reset goes to 1 on that edge.
  - req is sampled only in IDLE. Requests that arrive mid-sequence wait.
- Assert order: ASSERT_PROC -> ASSERT_PERI (scope>=01) -> ASSERT_ICN (scope 1x) -> HOLD. Out-of-scope states are skipped with no dead cycles.
- Release order: REL_ICN (scope 1x) -> REL_PERI (scope>=01) -> REL_PROC -> ACK. Out-of-scope states are skipped the same way.
- Out-of-scope reset outputs never toggle.
- ACK:
  - ack[grant_id]=1 on entry and is held.
  - When req[grant_id]==0 is sampled, ack drops and the state goes to IDLE on the same edge.
  - busy stays 1 throughout ACK.
- Simultaneous events:
  - Multiple req bits in IDLE: the lowest index wins; the others remain pending.
  - req_scope changes after grant are ignored.
- async_reset mid-sequence: outputs return to the reset values immediately and any in-flight ack is dropped. The sequence restarts at POR_HOLD with no ack to the interrupted requester.
- A requester dropping req before ack is a protocol violation. The sequence still completes, and ACK exits on its first cycle.

Optional Feature:
- Macro: RESET_SCHED_RR_EN.
- Defined: IDLE grants round-robin. Search starts at (last grant_id+1) mod NUM_REQ; the pointer resets to 0 and updates on each grant.
- Undefined: fixed priority, lowest index wins. No pointer register is built.

Test Plan:
- POR: async_reset released before edge 1, defaults, no req -> intercnct_reset falls at edge 16, periferal_reset at edge 20, processor_reset at edge 24; busy falls at edge 28; ack stays 0.
- Full-scope request: req[1]=1 with scope 2'b10 sampled in IDLE at edge g:
  - processor_reset rises at g, periferal_reset at g+4, intercnct_reset at g+8.
  - intercnct_reset falls at g+28, periferal_reset at g+32, processor_reset at g+36.
  - ack[1]=1 at g+40 and holds until req[1] drops; grant_id=1 throughout.
- Processor-only scope: req[0] with scope 2'b00 at g -> processor_reset is high from g to g+20; other resets never toggle; ack[0] rises at g+24.
- Contention: req=3'b110 in IDLE -> requester 1 served first and requester 2 granted on the first IDLE cycle after ack[1] drops. With RESET_SCHED_RR_EN, after requester 2 is served, req=3'b111 grants requester 0.
- Reset mid-sequence: async_reset pulsed during HOLD -> all resets high and ack=0 immediately; after release the POR timing above repeats exactly.
- Request held through ACK: req[2] kept high 10 cycles after ack -> ack[2] high all 10 cycles, busy=1; both drop on the edge after req[2] falls.
